// File: rtl/operand_fetch.sv
// operand_fetch: stage between decode and execute.
//   Accepts one decoded instruction (i_dec_* / o_dec_ready), issues rs1/rs2
//   register-file reads over independent AR/R valid/ready channels, snoops
//   write-back to bypass fresh values, then presents the operand bundle to
//   execute (o_ex_* / i_ex_ready). i_flush abandons the held instruction and
//   drains any outstanding read responses. clk/rstn: synchronous active-low reset.

// Per-source read tracker: AR_PEND -> R_PEND -> DONE, plus captured operand.
//   load/load_need/load_addr : start a new instruction (addr is 0 if unused)
//   fetch/drain/flush        : stage state qualifiers from the parent FSM
//   arvalid/arready/araddr   : read address channel
//   rvalid/rready/rdata      : read data channel
//   wb_*                     : write-back snoop
//   data                     : captured operand
//   done_nxt/rpend_nxt       : tracker state after this cycle
module operand_fetch_src #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            load_need,
    input  logic [4:0]      load_addr,
    input  logic            fetch,
    input  logic            drain,
    input  logic            flush,
    output logic            arvalid,
    input  logic            arready,
    output logic [4:0]      araddr,
    input  logic            rvalid,
    output logic            rready,
    input  logic [XLEN-1:0] rdata,
    input  logic            wb_wen,
    input  logic [4:0]      wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic [XLEN-1:0] data,
    output logic            done_nxt,
    output logic            rpend_nxt
);
    typedef enum logic [1:0] {T_DONE, T_AR, T_R} trk_t;

    trk_t       trk, trk_nxt;
    logic [4:0] addr;
    logic       ar_hs, r_ok, snoop;

    // addr is only loaded on accept, so it is stable while arvalid is high
    assign araddr = addr;

    always_comb begin
        arvalid = fetch && (trk == T_AR);
        rready  = (fetch && (trk != T_DONE)) || (drain && (trk == T_R));
        ar_hs   = arvalid && arready;
        // R only counts once its AR has completed (or completes now)
        r_ok    = rready && rvalid && ((trk == T_R) || ar_hs);
        // unneeded sources hold addr 0, so they are never snooped
        snoop   = wb_wen && (wb_waddr == addr) && (addr != 5'd0);
        trk_nxt = trk;
        if (fetch) begin
            if (r_ok)       trk_nxt = T_DONE;
            else if (ar_hs) trk_nxt = T_R;
            // flush withdraws an unaccepted AR; an accepted one must drain
            if (flush && (trk_nxt == T_AR)) trk_nxt = T_DONE;
        end else if (drain && r_ok) begin
            trk_nxt = T_DONE;
        end
        done_nxt  = (trk_nxt == T_DONE);
        rpend_nxt = (trk_nxt == T_R);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            trk  <= T_DONE;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            trk  <= load_need ? T_AR : T_DONE;
            addr <= load_need ? load_addr : 5'd0;
            data <= '0;
        end else begin
            trk <= trk_nxt;
            if (fetch) begin
                if (snoop && (trk == T_DONE || r_ok)) data <= wb_wdata;
                else if (r_ok)                        data <= rdata;
            end
        end
    end
endmodule

// Top: FSM IDLE/FETCH/ISSUE/DRAIN and registered pass-through fields.
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_flush,
    input  logic              i_dec_valid,
    output logic              o_dec_ready,
    input  logic [4:0]        i_dec_rs1,
    input  logic [4:0]        i_dec_rs2,
    input  logic              i_dec_use_rs1,
    input  logic              i_dec_use_rs2,
    input  logic [4:0]        i_dec_rd,
    input  logic [XLEN-1:0]   i_dec_imm,
    input  logic [XLEN-1:0]   i_dec_pc,
    input  logic [CTRL_W-1:0] i_dec_ctrl,
    output logic              o_rs1_arvalid,
    input  logic              i_rs1_arready,
    output logic [4:0]        o_rs1_araddr,
    input  logic              i_rs1_rvalid,
    output logic              o_rs1_rready,
    input  logic [XLEN-1:0]   i_rs1_rdata,
    output logic              o_rs2_arvalid,
    input  logic              i_rs2_arready,
    output logic [4:0]        o_rs2_araddr,
    input  logic              i_rs2_rvalid,
    output logic              o_rs2_rready,
    input  logic [XLEN-1:0]   i_rs2_rdata,
    input  logic              i_wb_wen,
    input  logic [4:0]        i_wb_waddr,
    input  logic [XLEN-1:0]   i_wb_wdata,
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [XLEN-1:0]   o_ex_rs1_data,
    output logic [XLEN-1:0]   o_ex_rs2_data,
    output logic [4:0]        o_ex_rd,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [CTRL_W-1:0] o_ex_ctrl
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN} state_t;

    state_t state, state_nxt;
    logic   accept;

    logic [1:0]            need, arvalid, arready, rvalid, rready, done_nxt, rpend_nxt;
    logic [1:0][4:0]       rs, araddr;
    logic [1:0][XLEN-1:0]  rdata, data;

    assign rs      = {i_dec_rs2, i_dec_rs1};
    assign need    = {i_dec_use_rs2 && (i_dec_rs2 != 5'd0),
                      i_dec_use_rs1 && (i_dec_rs1 != 5'd0)};
    assign arready = {i_rs2_arready, i_rs1_arready};
    assign rvalid  = {i_rs2_rvalid, i_rs1_rvalid};
    assign rdata   = {i_rs2_rdata, i_rs1_rdata};

    assign o_rs1_arvalid = arvalid[0];
    assign o_rs2_arvalid = arvalid[1];
    assign o_rs1_araddr  = araddr[0];
    assign o_rs2_araddr  = araddr[1];
    assign o_rs1_rready  = rready[0];
    assign o_rs2_rready  = rready[1];
    assign o_ex_rs1_data = data[0];
    assign o_ex_rs2_data = data[1];

    for (genvar s = 0; s < 2; s++) begin : g_src
        operand_fetch_src #(.XLEN(XLEN)) u_src (
            .clk      (clk),
            .rstn     (rstn),
            .load     (accept),
            .load_need(need[s]),
            .load_addr(rs[s]),
            .fetch    (state == S_FETCH),
            .drain    (state == S_DRAIN),
            .flush    (i_flush),
            .arvalid  (arvalid[s]),
            .arready  (arready[s]),
            .araddr   (araddr[s]),
            .rvalid   (rvalid[s]),
            .rready   (rready[s]),
            .rdata    (rdata[s]),
            .wb_wen   (i_wb_wen),
            .wb_waddr (i_wb_waddr),
            .wb_wdata (i_wb_wdata),
            .data     (data[s]),
            .done_nxt (done_nxt[s]),
            .rpend_nxt(rpend_nxt[s])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        o_dec_ready = rstn && (state == S_IDLE) && !i_flush;
        o_ex_valid  = (state == S_ISSUE);
        accept      = i_dec_valid && o_dec_ready;
        state_nxt   = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (|need) ? S_FETCH : S_ISSUE;
            S_FETCH: begin
                if (i_flush)        state_nxt = (|rpend_nxt) ? S_DRAIN : S_IDLE;
                else if (&done_nxt) state_nxt = S_ISSUE;
            end
            S_ISSUE: if (i_flush || i_ex_ready) state_nxt = S_IDLE;
            S_DRAIN: if (!(|rpend_nxt)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_ex_rd   <= '0;
            o_ex_imm  <= '0;
            o_ex_pc   <= '0;
            o_ex_ctrl <= '0;
        end else if (accept) begin
            o_ex_rd   <= i_dec_rd;
            o_ex_imm  <= i_dec_imm;
            o_ex_pc   <= i_dec_pc;
            o_ex_ctrl <= i_dec_ctrl;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch. Inputs change 1 time unit after each
// rising edge; outputs are checked 2 time units after it.
module tb_operand_fetch;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0, rstn = 1'b0, i_flush = 1'b0;
    logic              i_dec_valid = 1'b0, o_dec_ready;
    logic [4:0]        i_dec_rs1 = '0, i_dec_rs2 = '0, i_dec_rd = '0;
    logic              i_dec_use_rs1 = 1'b0, i_dec_use_rs2 = 1'b0;
    logic [XLEN-1:0]   i_dec_imm = '0, i_dec_pc = '0;
    logic [CTRL_W-1:0] i_dec_ctrl = '0;
    logic              o_rs1_arvalid, i_rs1_arready = 1'b0, i_rs1_rvalid = 1'b0, o_rs1_rready;
    logic              o_rs2_arvalid, i_rs2_arready = 1'b0, i_rs2_rvalid = 1'b0, o_rs2_rready;
    logic [4:0]        o_rs1_araddr, o_rs2_araddr;
    logic [XLEN-1:0]   i_rs1_rdata = '0, i_rs2_rdata = '0;
    logic              i_wb_wen = 1'b0;
    logic [4:0]        i_wb_waddr = '0;
    logic [XLEN-1:0]   i_wb_wdata = '0;
    logic              o_ex_valid, i_ex_ready = 1'b0;
    logic [XLEN-1:0]   o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_pc;
    logic [4:0]        o_ex_rd;
    logic [CTRL_W-1:0] o_ex_ctrl;

    int nchk = 0, npass = 0, nfail = 0;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rstn(rstn), .i_flush(i_flush),
        .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready),
        .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
        .i_dec_use_rs1(i_dec_use_rs1), .i_dec_use_rs2(i_dec_use_rs2),
        .i_dec_rd(i_dec_rd), .i_dec_imm(i_dec_imm), .i_dec_pc(i_dec_pc), .i_dec_ctrl(i_dec_ctrl),
        .o_rs1_arvalid(o_rs1_arvalid), .i_rs1_arready(i_rs1_arready), .o_rs1_araddr(o_rs1_araddr),
        .i_rs1_rvalid(i_rs1_rvalid), .o_rs1_rready(o_rs1_rready), .i_rs1_rdata(i_rs1_rdata),
        .o_rs2_arvalid(o_rs2_arvalid), .i_rs2_arready(i_rs2_arready), .o_rs2_araddr(o_rs2_araddr),
        .i_rs2_rvalid(i_rs2_rvalid), .o_rs2_rready(o_rs2_rready), .i_rs2_rdata(i_rs2_rdata),
        .i_wb_wen(i_wb_wen), .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
        .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
        .o_ex_rd(o_ex_rd), .o_ex_imm(o_ex_imm), .o_ex_pc(o_ex_pc), .o_ex_ctrl(o_ex_ctrl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle and return every per-cycle input to idle
    task automatic cyc();
        @(posedge clk);
        #1;
        i_dec_valid = 1'b0; i_flush = 1'b0; i_ex_ready = 1'b0;
        i_rs1_arready = 1'b0; i_rs1_rvalid = 1'b0; i_rs1_rdata = '0;
        i_rs2_arready = 1'b0; i_rs2_rvalid = 1'b0; i_rs2_rdata = '0;
        i_wb_wen = 1'b0; i_wb_waddr = '0; i_wb_wdata = '0;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [15:0] ctrl);
        i_dec_valid = 1'b1; i_dec_rs1 = rs1; i_dec_rs2 = rs2;
        i_dec_use_rs1 = u1; i_dec_use_rs2 = u2; i_dec_rd = rd;
        i_dec_imm = imm; i_dec_pc = pc; i_dec_ctrl = ctrl;
    endtask

    initial begin
        // ---- reset
        cyc(); cyc();
        #1;
        chk("rst_ex_valid", 32'(o_ex_valid), 32'd0);
        chk("rst_arvalid1", 32'(o_rs1_arvalid), 32'd0);
        chk("rst_rready1", 32'(o_rs1_rready), 32'd0);
        chk("rst_ex_pc", o_ex_pc, 32'd0);
        chk("rst_dec_ready_low", 32'(o_dec_ready), 32'd0);
        cyc(); rstn = 1'b1;
        #1 chk("rst_dec_ready", 32'(o_dec_ready), 32'd1);

        // ---- flush in IDLE: nothing accepted
        cyc(); dec(5'd5, 5'd6, 1'b1, 1'b1, 5'd1, 32'h0, 32'h0, 16'h0); i_flush = 1'b1;
        #1 chk("idle_flush_ready", 32'(o_dec_ready), 32'd0);
        cyc();
        #1 chk("idle_flush_arv", 32'(o_rs1_arvalid), 32'd0);
        chk("idle_flush_still_idle", 32'(o_dec_ready), 32'd1);

        // ---- zero-wait add x7,x5,x6
        dec(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 32'h100, 32'h40, 16'h1234);
        cyc();
        i_rs1_arready = 1'b1; i_rs1_rvalid = 1'b1; i_rs1_rdata = 32'h11;
        i_rs2_arready = 1'b1; i_rs2_rvalid = 1'b1; i_rs2_rdata = 32'h22;
        #1 chk("zw_arv1", 32'(o_rs1_arvalid), 32'd1);
        chk("zw_arv2", 32'(o_rs2_arvalid), 32'd1);
        chk("zw_araddr1", 32'(o_rs1_araddr), 32'd5);
        chk("zw_araddr2", 32'(o_rs2_araddr), 32'd6);
        chk("zw_rready1", 32'(o_rs1_rready), 32'd1);
        chk("zw_ex_valid_c1", 32'(o_ex_valid), 32'd0);
        cyc(); i_ex_ready = 1'b1;
        #1 chk("zw_ex_valid_c2", 32'(o_ex_valid), 32'd1);
        chk("zw_rs1", o_ex_rs1_data, 32'h11);
        chk("zw_rs2", o_ex_rs2_data, 32'h22);
        chk("zw_rd", 32'(o_ex_rd), 32'd7);
        chk("zw_imm", o_ex_imm, 32'h100);
        chk("zw_pc", o_ex_pc, 32'h40);
        chk("zw_ctrl", 32'(o_ex_ctrl), 32'h1234);
        chk("zw_dec_ready_c2", 32'(o_dec_ready), 32'd0);
        cyc();
        #1 chk("zw_ex_valid_c3", 32'(o_ex_valid), 32'd0);
        chk("zw_dec_ready_c3", 32'(o_dec_ready), 32'd1);

        // ---- rs2 arready delayed 3 cycles
        dec(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 32'h0, 32'h44, 16'h0);
        cyc(); i_rs1_arready = 1'b1; i_rs1_rvalid = 1'b1; i_rs1_rdata = 32'h55;
        #1 chk("dl_arv2_c1", 32'(o_rs2_arvalid), 32'd1);
        for (int c = 2; c <= 3; c++) begin
            cyc(); i_rs1_rvalid = 1'b1; i_rs1_rdata = 32'hDEAD;
            #1 chk("dl_arv1_off", 32'(o_rs1_arvalid), 32'd0);
            chk("dl_arv2_hold", 32'(o_rs2_arvalid), 32'd1);
            chk("dl_araddr2_stable", 32'(o_rs2_araddr), 32'd6);
            chk("dl_ex_valid", 32'(o_ex_valid), 32'd0);
        end
        cyc(); i_rs2_arready = 1'b1; i_rs2_rvalid = 1'b1; i_rs2_rdata = 32'h66;
        #1 chk("dl_ex_valid_c4", 32'(o_ex_valid), 32'd0);
        cyc(); i_ex_ready = 1'b1;
        #1 chk("dl_ex_valid_c5", 32'(o_ex_valid), 32'd1);
        chk("dl_rs1", o_ex_rs1_data, 32'h55);
        chk("dl_rs2", o_ex_rs2_data, 32'h66);
        cyc();

        // ---- lui-style: no sources
        dec(5'd5, 5'd6, 1'b0, 1'b0, 5'd9, 32'hABC000, 32'h48, 16'h0);
        cyc(); i_ex_ready = 1'b1;
        #1 chk("lui_arv1", 32'(o_rs1_arvalid), 32'd0);
        chk("lui_arv2", 32'(o_rs2_arvalid), 32'd0);
        chk("lui_ex_valid", 32'(o_ex_valid), 32'd1);
        chk("lui_rs1", o_ex_rs1_data, 32'd0);
        chk("lui_rs2", o_ex_rs2_data, 32'd0);
        chk("lui_imm", o_ex_imm, 32'hABC000);
        cyc();

        // ---- rs1 = x0 with use_rs1
        dec(5'd0, 5'd6, 1'b1, 1'b0, 5'd10, 32'h0, 32'h4C, 16'h0);
        cyc(); i_ex_ready = 1'b1;
        #1 chk("x0_arv1", 32'(o_rs1_arvalid), 32'd0);
        chk("x0_ex_valid", 32'(o_ex_valid), 32'd1);
        chk("x0_rs1", o_ex_rs1_data, 32'd0);
        cyc();

        // ---- snoop on a DONE source in a later FETCH cycle
        dec(5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 32'h0, 32'h50, 16'h0);
        cyc(); i_rs1_arready = 1'b1;
        #1 chk("sn_arv1_c1", 32'(o_rs1_arvalid), 32'd1);
        cyc(); i_rs1_rvalid = 1'b1; i_rs1_rdata = 32'hAAAA;
        #1 chk("sn_arv1_c2", 32'(o_rs1_arvalid), 32'd0);
        chk("sn_rready1_c2", 32'(o_rs1_rready), 32'd1);
        cyc(); i_wb_wen = 1'b1; i_wb_waddr = 5'd9; i_wb_wdata = 32'hBBBB;
        i_rs2_arready = 1'b1; i_rs2_rvalid = 1'b1; i_rs2_rdata = 32'h1010;
        cyc(); i_ex_ready = 1'b1;
        #1 chk("sn_ex_valid", 32'(o_ex_valid), 32'd1);
        chk("sn_rs1_bypass", o_ex_rs1_data, 32'hBBBB);
        chk("sn_rs2", o_ex_rs2_data, 32'h1010);
        cyc();

        // ---- same-cycle rdata+snoop, and snoop to x0 ignored
        dec(5'd12, 5'd0, 1'b1, 1'b1, 5'd13, 32'h0, 32'h54, 16'h0);
        cyc(); i_rs1_arready = 1'b1;
        i_wb_wen = 1'b1; i_wb_waddr = 5'd0; i_wb_wdata = 32'hFFFF;
        cyc(); i_rs1_rvalid = 1'b1; i_rs1_rdata = 32'hC0C0;
        i_wb_wen = 1'b1; i_wb_waddr = 5'd12; i_wb_wdata = 32'hD0D0;

        // ---- stall in ISSUE while write-back hits the same register
        for (int c = 0; c < 4; c++) begin
            cyc(); i_wb_wen = 1'b1; i_wb_waddr = 5'd12; i_wb_wdata = 32'hEEEE;
            #1 chk("st_ex_valid", 32'(o_ex_valid), 32'd1);
            chk("st_rs1_hold", o_ex_rs1_data, 32'hD0D0);
            chk("st_rs2_x0", o_ex_rs2_data, 32'd0);
        end
        cyc(); i_ex_ready = 1'b1;
        #1 chk("st_rs1_accept", o_ex_rs1_data, 32'hD0D0);
        chk("st_rd", 32'(o_ex_rd), 32'd13);
        cyc();
        #1 chk("st_ex_valid_after", 32'(o_ex_valid), 32'd0);
        chk("st_dec_ready_after", 32'(o_dec_ready), 32'd1);

        // ---- flush with AR still pending: straight back to IDLE
        dec(5'd5, 5'd0, 1'b1, 1'b0, 5'd1, 32'h0, 32'h58, 16'h0);
        cyc(); i_flush = 1'b1;
        #1 chk("fa_arv1", 32'(o_rs1_arvalid), 32'd1);
        cyc();
        #1 chk("fa_arv1_drop", 32'(o_rs1_arvalid), 32'd0);
        chk("fa_idle", 32'(o_dec_ready), 32'd1);

        // ---- flush with rs1 in R_PEND: drain
        dec(5'd5, 5'd0, 1'b1, 1'b0, 5'd2, 32'h0, 32'h5C, 16'h0);
        cyc(); i_rs1_arready = 1'b1;
        cyc(); i_flush = 1'b1;
        #1 chk("fr_rready_flush", 32'(o_rs1_rready), 32'd1);
        chk("fr_dec_ready_flush", 32'(o_dec_ready), 32'd0);
        cyc();
        #1 chk("fr_drain_rready", 32'(o_rs1_rready), 32'd1);
        chk("fr_drain_arv", 32'(o_rs1_arvalid), 32'd0);
        chk("fr_drain_ex_valid", 32'(o_ex_valid), 32'd0);
        chk("fr_drain_dec_ready", 32'(o_dec_ready), 32'd0);
        cyc(); i_rs1_rvalid = 1'b1; i_rs1_rdata = 32'h9999;
        #1 chk("fr_drain_rready2", 32'(o_rs1_rready), 32'd1);
        cyc();
        #1 chk("fr_idle", 32'(o_dec_ready), 32'd1);
        chk("fr_idle_ex_valid", 32'(o_ex_valid), 32'd0);
        chk("fr_idle_rready", 32'(o_rs1_rready), 32'd0);

        // ---- next instruction after drain, rs1 == rs2
        dec(5'd5, 5'd5, 1'b1, 1'b1, 5'd3, 32'h0, 32'h60, 16'h0);
        cyc();
        i_rs1_arready = 1'b1; i_rs1_rvalid = 1'b1; i_rs1_rdata = 32'h11;
        i_rs2_arready = 1'b1; i_rs2_rvalid = 1'b1; i_rs2_rdata = 32'h11;
        #1 chk("eq_arv1", 32'(o_rs1_arvalid), 32'd1);
        chk("eq_arv2", 32'(o_rs2_arvalid), 32'd1);
        chk("eq_araddr2", 32'(o_rs2_araddr), 32'd5);
        cyc(); i_ex_ready = 1'b1;
        #1 chk("eq_ex_valid", 32'(o_ex_valid), 32'd1);
        chk("eq_rs1", o_ex_rs1_data, 32'h11);
        chk("eq_rs2", o_ex_rs2_data, 32'h11);
        chk("eq_pc", o_ex_pc, 32'h60);
        cyc();

        // ---- reset mid-FETCH
        dec(5'd5, 5'd0, 1'b1, 1'b0, 5'd4, 32'h7, 32'h80, 16'h55);
        cyc(); rstn = 1'b0;
        #1 chk("mr_arv1_before", 32'(o_rs1_arvalid), 32'd1);
        cyc();
        #1 chk("mr_arv1", 32'(o_rs1_arvalid), 32'd0);
        chk("mr_araddr1", 32'(o_rs1_araddr), 32'd0);
        chk("mr_rready1", 32'(o_rs1_rready), 32'd0);
        chk("mr_ex_valid", 32'(o_ex_valid), 32'd0);
        chk("mr_rd", 32'(o_ex_rd), 32'd0);
        chk("mr_pc", o_ex_pc, 32'd0);
        chk("mr_ctrl", 32'(o_ex_ctrl), 32'd0);
        cyc(); rstn = 1'b1;
        #1 chk("mr_dec_ready", 32'(o_dec_ready), 32'd1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
